// File: rtl/spi_brightness_rx.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi on sysclk, decodes {enable, duty} frames; SPI_READBACK_EN adds readback on o_miso.
// Latency: o_valid rises SYNC_STAGES+2 sysclk cycles after the frame-completing SCLK rising edge at the pin.
// Backpressure: none; outputs are held until the next accepted frame, each accept pulses o_valid once.
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 7
`endif

module spi_brightness_rx #(
    parameter int BRIGHTNESS_WIDTH = `BRIGHTNESS_WIDTH,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        sysclk,
    input  logic                        rst,
    input  logic                        i_sclk,
    input  logic                        i_cs_n,
    input  logic                        i_mosi,
    output logic                        o_miso,
    output logic                        o_enb,
    output logic [BRIGHTNESS_WIDTH-1:0] o_d,
    output logic                        o_valid,
    output logic                        o_frame_err
);
    localparam int FRAME_W = BRIGHTNESS_WIDTH + 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0]      r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                        r_sclk_prev, r_cs_prev;
    logic                        w_sclk, w_cs_n, w_mosi, w_sclk_rise, w_cs_fall;
    logic [FRAME_W-1:0]          r_shreg;
    logic [CNT_W-1:0]            r_bit_cnt;
    logic                        r_enb, r_valid, r_frame_err;
    logic [BRIGHTNESS_WIDTH-1:0] r_d;
    logic                        w_clr, w_shift, w_load, w_err;

    // cs_prev resets low, so a falling edge only counts once cs_n has been seen high
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_cs_fall   = ~w_cs_n & r_cs_prev;

    always_ff @(posedge sysclk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_clr       = 1'b1;
                end
            end
            SHIFT: begin
                // a final edge coinciding with cs_n release still completes the frame
                if (r_bit_cnt == CNT_FULL) begin
                    w_load      = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                end else if (w_cs_n) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                if (w_cs_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_enb       <= 1'b0;
            r_d         <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_load;
            r_frame_err <= w_err;
            if (w_clr)
                r_bit_cnt <= '0;
            else if (w_shift && r_bit_cnt != CNT_FULL)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift)
                r_shreg <= {r_shreg[FRAME_W-2:0], w_mosi};
            if (w_load) begin
                r_enb <= r_shreg[FRAME_W-1];
                r_d   <= r_shreg[BRIGHTNESS_WIDTH-1:0];
            end
        end
    end

    assign o_enb       = r_enb;
    assign o_d         = r_d;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

`ifdef SPI_READBACK_EN
    logic [FRAME_W-1:0] r_rb;
    logic [CNT_W-1:0]   r_rb_cnt;
    logic               r_miso;
    logic               w_sclk_fall;

    assign w_sclk_fall = ~w_sclk & r_sclk_prev;

    // MSB leaves on cs_n fall; each later bit leaves on a synced SCLK fall, then 0
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_rb     <= '0;
            r_rb_cnt <= '0;
            r_miso   <= 1'b0;
        end else if (r_state == IDLE) begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
                r_miso   <= r_enb;
                r_rb     <= {r_d, 1'b0};
                r_rb_cnt <= CNT_W'(1);
            end
        end else if (w_sclk_fall) begin
            if (r_rb_cnt < CNT_FULL) begin
                r_miso   <= r_rb[FRAME_W-1];
                r_rb     <= {r_rb[FRAME_W-2:0], 1'b0};
                r_rb_cnt <= r_rb_cnt + 1'b1;
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    assign o_miso = r_miso;
`else
    assign o_miso = 1'b0;
`endif

endmodule
